pwm_gen: RTL and testbench

PWM generator directly downstream of the frequency divider. Samples the divider's output as a plain data signal in the system clock domain and advances a period counter one step per divided-clock rising edge. Produces a duty-cycle–modulated output whose duty word comes from the PID controller over a valid/ready handshake. Duty updates are double-buffered, so a new value only takes effect at a period boundary.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_gen_edge_sync.sv | 32 +++
 rtl/pwm_gen.sv | 99 +++++++++
 tb/tb_pwm_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM path: default counter width, default
// period length and the duty word type exchanged with the PID controller.
package pwm_pkg;

    localparam int CNT_WIDTH_DEF = 16;
    localparam int PERIOD_DEF    = 1000;

    // Duty word at the default width, as produced by pid_ctrl.
    typedef logic [CNT_WIDTH_DEF-1:0] duty_t;

endpackage : pwm_pkg

// File: rtl/pwm_gen_edge_sync.sv
// Brings a slow, unrelated tick into the clk domain and produces a
// one-cycle step pulse for every rising edge of that tick.
module edge_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_step
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Step is high for exactly one cycle after the synchronized level rises.
    assign o_step = r_s2 & ~r_s3;

endmodule : edge_sync

// File: rtl/pwm_gen.sv
// PWM generator: period counter stepped by the divided clock, a
// double-buffered duty register fed over valid/ready, and a registered
// compare output. New duty values only take effect at a period wrap
// (or immediately while the generator is stopped).
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int PERIOD    = PERIOD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] duty_in,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    output logic                 pwm_out,
    output logic                 period_start
);

    localparam logic [CNT_WIDTH-1:0] PERIOD_W = CNT_WIDTH'(PERIOD);
    localparam logic [CNT_WIDTH-1:0] LAST_W   = CNT_WIDTH'(PERIOD - 1);

    logic                 w_step;
    logic                 w_at_end;
    logic                 w_wrap;
    logic                 w_xfer;
    logic                 w_apply;
    logic [CNT_WIDTH-1:0] w_duty_clamped;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_duty_active;
    logic [CNT_WIDTH-1:0] r_duty_pending;
    logic                 r_pending_full;
    logic                 r_pwm;
    logic                 r_period_start;

    edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (tick_in),
        .o_step  (w_step)
    );

    assign w_at_end = (r_cnt == LAST_W);
    assign w_wrap   = enable & w_step & w_at_end;

    // Requests above one full period would be meaningless; saturate them.
    assign w_duty_clamped = (duty_in > PERIOD_W) ? PERIOD_W : duty_in;

    // Ready is forced low during reset so nothing is accepted then.
    assign duty_ready = ~r_pending_full & ~rst;
    assign w_xfer     = duty_valid & duty_ready;

    // Pending moves to active at a wrap, or at once while stopped.
    assign w_apply = r_pending_full & (~enable | w_wrap);

    // Period counter, wrap pulse and compare output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else if (!enable) begin
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_step) begin
                r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
            end
            // Compare uses the registered count, so the output lags it by one.
            r_pwm <= (r_cnt < r_duty_active);
        end
    end

    // Duty double buffer: accept into pending, promote to active on apply.
    // Apply needs a full buffer and transfer needs an empty one, so the
    // two branches never compete in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active  <= '0;
            r_duty_pending <= '0;
            r_pending_full <= 1'b0;
        end else if (w_apply) begin
            r_duty_active  <= r_duty_pending;
            r_pending_full <= 1'b0;
        end else if (w_xfer) begin
            r_duty_pending <= w_duty_clamped;
            r_pending_full <= 1'b1;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen with a short period. The stimulus keeps a duty-level
// model (active / pending) and queues, per PWM period, how many clk cycles
// the output must spend high and low. A monitor measures each period
// between period_start pulses and checks it against the queue.
module tb_pwm_gen;

    localparam int CW   = 8;
    localparam int P    = 20;
    localparam int TCLK = 8;   // clk cycles per divided-clock step

    logic          clk;
    logic          rst;
    logic          tick_in;
    logic          enable;
    logic [CW-1:0] duty_in;
    logic          duty_valid;
    logic          duty_ready;
    logic          pwm_out;
    logic          period_start;

    pwm_gen #(.CNT_WIDTH(CW), .PERIOD(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    typedef struct {
        int hi;
        int lo;
        bit chk_hi;
        bit chk_lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Duty-level reference model
    int m_active = 0;
    int m_pend   = 0;
    bit m_pend_v = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divided clock: toggles every 4 clk, so one rising edge per TCLK cycles.
    initial begin
        tick_in = 1'b0;
        forever begin
            repeat (4) @(posedge clk);
            #2 tick_in = ~tick_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int clampd(input int d);
        return (d > P) ? P : d;
    endfunction

    // A complete period with duty d: high while count < d, each count lasting TCLK.
    task automatic push_normal();
        exp_t e;
        e = '{TCLK * m_active, TCLK * (P - m_active), 1'b1, 1'b1};
        sb_q.push_back(e);
    endtask

    // First period after start: the count sits at 0 for an unknown phase, so
    // only the phase-independent half can be predicted.
    task automatic push_first();
        exp_t e;
        if (m_active == 0) e = '{0, 0, 1'b1, 1'b0};
        else               e = '{0, TCLK * (P - m_active), 1'b0, 1'b1};
        sb_q.push_back(e);
    endtask

    // Wait for a wrap; the model promotes pending and expects a new period.
    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 400);
        if (!period_start) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ps: got no period_start in %0d cycles required pulse", k);
        end
        if (m_pend_v) begin
            m_active = m_pend;
            m_pend_v = 1'b0;
        end
        push_normal();
    endtask

    task automatic transfer(input int d);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        duty_in    = CW'(d);
        duty_valid = 1'b1;
        while (!acc && k < 400) begin
            acc = duty_ready;
            @(posedge clk);
            k++;
        end
        #1 duty_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: got ready=0 for %0d cycles required acceptance", k);
        end else begin
            m_pend   = clampd(d);
            m_pend_v = 1'b1;
            $display("xfer duty=%0d stored=%0d", d, m_pend);
        end
        @(negedge clk);
        chk("ready_after_xfer", int'(duty_ready), 0);
    endtask

    task automatic period_with(input int d, input int dly);
        repeat (dly) @(posedge clk);
        #1;
        transfer(d);
        wait_ps();
    endtask

    // Monitor: measures high/low cycles in each period window and checks it.
    bit mon_open = 1'b0;
    bit mon_prev = 1'b0;
    int mon_hi   = 0;
    int mon_lo   = 0;

    always @(negedge clk) begin
        bit   run;
        exp_t e;
        run = enable && !rst;
        if (!run) begin
            mon_open = 1'b0;
            mon_hi   = 0;
            mon_lo   = 0;
        end else begin
            if (mon_open) begin
                if (pwm_out) mon_hi++;
                else         mon_lo++;
            end
            if (period_start || !mon_prev) begin
                if (mon_open) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_underflow: got period hi=%0d lo=%0d required queued entry", mon_hi, mon_lo);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk_hi) chk("period_high_cycles", mon_hi, e.hi);
                        if (e.chk_lo) chk("period_low_cycles", mon_lo, e.lo);
                    end
                end
                mon_open = 1'b1;
                mon_hi   = 0;
                mon_lo   = 0;
            end
        end
        mon_prev = run;
    end

    initial begin
        int d;
        int dly;
        rst        = 1'b1;
        enable     = 1'b0;
        duty_valid = 1'b0;
        duty_in    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_duty_ready", int'(duty_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(duty_ready), 1);

        // Basic run: duty 5 accepted while count is 0
        @(posedge clk);
        #1 enable = 1'b1;
        push_first();
        transfer(5);
        repeat (3) wait_ps();

        // Saturation above PERIOD, then zero duty
        period_with(30, 3);
        wait_ps();
        period_with(0, 3);
        wait_ps();

        // Back-to-back requests: second stalls until the wrap
        repeat (2) @(posedge clk);
        #1;
        transfer(6);
        duty_in    = CW'(12);
        duty_valid = 1'b1;
        @(negedge clk);
        chk("ready_stalled", int'(duty_ready), 0);
        wait_ps();
        chk("ready_at_wrap", int'(duty_ready), 1);
        @(posedge clk);
        #1 duty_valid = 1'b0;
        m_pend   = 12;
        m_pend_v = 1'b1;
        wait_ps();
        wait_ps();

        // Transfer in the period_start cycle itself
        transfer(15);
        wait_ps();
        wait_ps();

        // Stop mid-period with a pending duty, then restart
        repeat (2) @(posedge clk);
        #1;
        transfer(8);
        repeat (40) @(posedge clk);
        #1;
        void'(sb_q.pop_back());
        enable = 1'b0;
        m_active = m_pend;
        m_pend_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("disable_pwm_out", int'(pwm_out), 0);
        chk("disable_period_start", int'(period_start), 0);
        chk("disable_duty_ready", int'(duty_ready), 1);
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        push_first();
        wait_ps();
        wait_ps();

        // Reset mid-period with a pending duty: everything discarded
        repeat (2) @(posedge clk);
        #1;
        transfer(10);
        repeat (60) @(posedge clk);
        #1;
        void'(sb_q.pop_back());
        rst = 1'b1;
        m_active = 0;
        m_pend_v = 1'b0;
        @(negedge clk);
        chk("ready_in_rst", int'(duty_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pwm_out", int'(pwm_out), 0);
        chk("midrst_period_start", int'(period_start), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        push_first();
        @(negedge clk);
        chk("ready_after_midrst", int'(duty_ready), 1);
        wait_ps();
        wait_ps();

        // Randomized duties at random points in the period
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                dly = $urandom_range(0, 30);
                d   = $urandom_range(0, P + 8);
                repeat (dly) @(posedge clk);
                if (dly != 0) #1;
                transfer(d);
            end
            wait_ps();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pwm_gen
